// File: rtl/serial_link_payload_reassembler_if.sv
// Serial link receive stream bundle.
// Flit input, payload output and framing-error pulse.
interface serial_link_payload_reassembler_if #(
  parameter int PayloadWidth = 128,
  parameter int FlitWidth    = 32
);
  logic                    flit_valid_i;
  logic                    flit_ready_o;
  logic [FlitWidth-1:0]    flit_data_i;
  logic                    flit_sof_i;
  logic                    payload_valid_o;
  logic                    payload_ready_i;
  logic [PayloadWidth-1:0] payload_data_o;
  logic                    err_sof_o;

  modport master (
    output flit_valid_i,
    output flit_data_i,
    output flit_sof_i,
    output payload_ready_i,
    input  flit_ready_o,
    input  payload_valid_o,
    input  payload_data_o,
    input  err_sof_o
  );

  modport slave (
    input  flit_valid_i,
    input  flit_data_i,
    input  flit_sof_i,
    input  payload_ready_i,
    output flit_ready_o,
    output payload_valid_o,
    output payload_data_o,
    output err_sof_o
  );
endinterface

// File: rtl/serial_link_payload_reassembler.sv
// Reassembles SOF-framed narrow flits into wide payload words.
// Completing flit bypasses the buffer straight into the output register.
module serial_link_payload_reassembler #(
  parameter int PayloadWidth = 128,
  parameter int FlitWidth    = 32
) (
  input logic clk_i,
  input logic rst_ni,
  serial_link_payload_reassembler_if.slave bus
);
  localparam int NumFlits = (PayloadWidth + FlitWidth - 1) / FlitWidth;
  localparam int CntW     = (NumFlits > 1) ? $clog2(NumFlits) : 1;
  localparam int Slots    = (NumFlits > 1) ? NumFlits - 1 : 1;
  localparam int BufW     = NumFlits * FlitWidth;

  typedef enum logic {
    Hunt,
    Collect
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d, wr_idx;
  logic [Slots*FlitWidth-1:0] buf_q;
  logic [BufW-1:0]           full;
  logic                      wr_en, complete, restart;
  logic                      flit_ready, fire;
  logic                      pv_q, err_q;
  logic [PayloadWidth-1:0]   pd_q;

  // Slots 0..NumFlits-2 live in buf_q; the last slot is the live flit.
  if (NumFlits > 1) begin : g_multi
    assign full = {bus.flit_data_i, buf_q};
  end else begin : g_single
    assign full = bus.flit_data_i;
  end

  // Next-state, slot selection and flit backpressure.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_idx   = '0;
    wr_en    = 1'b0;
    complete = 1'b0;
    restart  = 1'b0;
    unique case (state_q)
      Hunt: begin
        if (bus.flit_sof_i) begin
          if (NumFlits == 1) begin
            complete = 1'b1;
          end else begin
            wr_en   = 1'b1;
            cnt_d   = CntW'(1);
            state_d = Collect;
          end
        end
      end
      Collect: begin
        if (bus.flit_sof_i) begin
          restart = 1'b1;
          wr_en   = 1'b1;
          cnt_d   = CntW'(1);
        end else if (cnt_q == CntW'(NumFlits - 1)) begin
          complete = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = cnt_q;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
    if (complete) begin
      cnt_d   = '0;
      state_d = Hunt;
    end
    flit_ready = !complete | !pv_q | bus.payload_ready_i;
    fire       = bus.flit_valid_i & flit_ready;
    if (!fire) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
    end
  end

  assign bus.flit_ready_o    = flit_ready;
  assign bus.payload_valid_o = pv_q;
  assign bus.payload_data_o  = pd_q;
  assign bus.err_sof_o       = err_q;

  // FSM state and slot counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Hunt;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Assembly buffer slot writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else begin
      for (int k = 0; k < Slots; k++) begin
        if (wr_en && wr_idx == CntW'(k)) begin
          buf_q[k*FlitWidth +: FlitWidth] <= bus.flit_data_i;
        end
      end
    end
  end

  // Output register and registered framing-error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q  <= 1'b0;
      pd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= fire & restart;
      if (fire & complete) begin
        pv_q <= 1'b1;
        pd_q <= full[PayloadWidth-1:0];
      end else if (bus.payload_ready_i) begin
        pv_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_link_payload_reassembler.sv
// Bench for serial_link_payload_reassembler.
// Directed and random flit traffic against a frame-queue model.
module tb_serial_link_payload_reassembler;
  localparam int P = 128;
  localparam int F = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_link_payload_reassembler_if #(.PayloadWidth(P), .FlitWidth(F)) bus ();
  serial_link_payload_reassembler_if #(.PayloadWidth(100), .FlitWidth(F)) bus2 ();

  serial_link_payload_reassembler #(.PayloadWidth(P), .FlitWidth(F)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  serial_link_payload_reassembler #(.PayloadWidth(100), .FlitWidth(F)) dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus2.slave)
  );

  int n_assert = 0;
  int n_fail = 0;
  int n_err_seen = 0;

  logic [F-1:0] frame[$];
  logic         exp_pv = 1'b0;
  logic [P-1:0] exp_pd = '0;
  logic         exp_err = 1'b0;

  task automatic chk(input string tag, input logic [P-1:0] obs,
                     input logic [P-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("payload_valid", P'(bus.payload_valid_o), P'(exp_pv));
    if (exp_pv) chk("payload_data", bus.payload_data_o, exp_pd);
    chk("err_sof", P'(bus.err_sof_o), P'(exp_err));
    if (bus.err_sof_o === 1'b1) n_err_seen++;
  endtask

  task automatic peek_word(input string tag, input logic [P-1:0] exp);
    chk({tag, "_valid"}, P'(bus.payload_valid_o), P'(1'b1));
    chk({tag, "_data"}, bus.payload_data_o, exp);
  endtask

  // One cycle: entered and left at a falling edge.
  task automatic step(input logic v, input logic s,
                      input logic [F-1:0] d, input logic pr);
    logic comp, rdy, load, nerr;
    logic [N*F-1:0] wfull;
    check_outputs();
    bus.flit_valid_i = v;
    bus.flit_sof_i = s;
    bus.flit_data_i = d;
    bus.payload_ready_i = pr;
    #1;
    comp = s ? (N == 1) : (frame.size() > 0 && frame.size() == N - 1);
    rdy = !comp || !exp_pv || pr;
    chk("flit_ready", P'(bus.flit_ready_o), P'(rdy));
    load = 1'b0;
    nerr = 1'b0;
    wfull = '0;
    if (v && rdy) begin
      if (s) begin
        if (frame.size() > 0) nerr = 1'b1;
        frame.delete();
        frame.push_back(d);
      end else if (frame.size() > 0) begin
        frame.push_back(d);
      end
      if (frame.size() == N) begin
        foreach (frame[k]) wfull[k*F +: F] = frame[k];
        load = 1'b1;
        frame.delete();
      end
    end
    if (load) begin
      exp_pv = 1'b1;
      exp_pd = wfull[P-1:0];
    end else if (pr) begin
      exp_pv = 1'b0;
    end
    exp_err = nerr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [F-1:0] base, input logic pr);
    for (int i = 0; i < N; i++) step(1'b1, i == 0, base + F'(i), pr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, P'(bus.payload_valid_o), '0);
    chk({tag, "_data"}, bus.payload_data_o, '0);
    chk({tag, "_err"}, P'(bus.err_sof_o), '0);
    chk({tag, "_ready"}, P'(bus.flit_ready_o), P'(1'b1));
  endtask

  initial begin
    int e0;
    logic [99:0] ones;
    ones = '1;
    bus.flit_valid_i = 1'b0;
    bus.flit_sof_i = 1'b0;
    bus.flit_data_i = '0;
    bus.payload_ready_i = 1'b0;
    bus2.flit_valid_i = 1'b0;
    bus2.flit_sof_i = 1'b0;
    bus2.flit_data_i = '0;
    bus2.payload_ready_i = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", P'(bus.flit_ready_o), P'(1'b1));
    @(negedge clk);

    // Basic frame.
    step(1'b1, 1'b1, 32'h11111111, 1'b1);
    step(1'b1, 1'b0, 32'h22222222, 1'b1);
    step(1'b1, 1'b0, 32'h33333333, 1'b1);
    step(1'b1, 1'b0, 32'h44444444, 1'b1);
    peek_word("basic", 128'h44444444_33333333_22222222_11111111);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("basic_no_err", P'(n_err_seen), '0);

    // Backpressure: second completing flit stalls until drain.
    send_frame(32'h100, 1'b0);
    for (int i = 0; i < N - 1; i++) step(1'b1, i == 0, 32'h200 + F'(i), 1'b0);
    step(1'b1, 1'b0, 32'h203, 1'b0);
    step(1'b1, 1'b0, 32'h203, 1'b0);
    peek_word("bp_hold", 128'h00000103_00000102_00000101_00000100);
    step(1'b1, 1'b0, 32'h203, 1'b1);
    peek_word("bp_second", 128'h00000203_00000202_00000201_00000200);
    step(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back frames with permanent ready.
    send_frame(32'h300, 1'b1);
    send_frame(32'h400, 1'b1);
    peek_word("b2b", 128'h00000403_00000402_00000401_00000400);

    // Hunt discard.
    step(1'b1, 1'b0, 32'hDEAD0000, 1'b1);
    step(1'b1, 1'b0, 32'hDEAD0001, 1'b1);
    send_frame(32'h500, 1'b1);
    peek_word("hunt", 128'h00000503_00000502_00000501_00000500);
    step(1'b0, 1'b0, '0, 1'b1);

    // Mid-frame SOF.
    e0 = n_err_seen;
    step(1'b1, 1'b1, 32'h1, 1'b1);
    step(1'b1, 1'b0, 32'h2, 1'b1);
    send_frame(32'hA, 1'b1);
    peek_word("midsof", 128'h0000000D_0000000C_0000000B_0000000A);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("midsof_err_count", P'(n_err_seen - e0), P'(1));

    // Framing restart while the output register is full.
    send_frame(32'h600, 1'b0);
    step(1'b1, 1'b1, 32'h700, 1'b0);
    step(1'b1, 1'b0, 32'h701, 1'b0);
    step(1'b1, 1'b1, 32'h800, 1'b0);
    peek_word("restart_full", 128'h00000603_00000602_00000601_00000600);
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-frame with a pending output word.
    send_frame(32'h900, 1'b0);
    step(1'b1, 1'b1, 32'hB00, 1'b0);
    step(1'b1, 1'b0, 32'hB01, 1'b0);
    bus.flit_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    frame.delete();
    exp_pv = 1'b0;
    exp_pd = '0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(32'hC00, 1'b1);
    peek_word("after_reset", 128'h00000C03_00000C02_00000C01_00000C00);
    step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 5) == 0, F'($urandom),
           ($urandom % 3) != 0);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Non-multiple payload width on the second instance.
    for (int i = 0; i < 4; i++) begin
      bus2.flit_valid_i = 1'b1;
      bus2.flit_sof_i = (i == 0);
      bus2.flit_data_i = 32'hFFFFFFFF;
      #1;
      chk("w100_ready", P'(bus2.flit_ready_o), P'(1'b1));
      @(negedge clk);
    end
    bus2.flit_valid_i = 1'b0;
    bus2.flit_sof_i = 1'b0;
    chk("w100_valid", P'(bus2.payload_valid_o), P'(1'b1));
    chk("w100_data", P'(bus2.payload_data_o), P'(ones));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
